ether_tx_scheduler: RTL and testbench

Arbitrates and sequences two GMII-style byte-stream packet sources onto a single transmit interface. Each source is a frame generator such as the sample ARP packet transmitter. The block grants sources round-robin, issues a start pulse, and muxes the granted source onto the TX bus with one cycle of registered latency. It enforces the Ethernet inter-frame gap and aborts runaway frames with a watchdog. It sits between the packet generators and the GMII TX pins.

---
 rtl/ether_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_ether_tx_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_tx_scheduler.sv
// Round-robin scheduler muxing two GMII byte-stream sources onto one TX port, with IFG and watchdog.
// Latency: one registered cycle from the granted source's en/er/data to tx_en/tx_er/tx_data.
// Backpressure: none on the byte path; a source waits for its start pulse, and an idle source loses its grant.
module ether_tx_scheduler #(
   parameter int IFG_CYCLES    = 12,
   parameter int START_TIMEOUT = 16,
   parameter int MAX_FRAME     = 1530
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  req,
   output logic [1:0]  start,
   output logic [1:0]  gnt,
   input  logic        src0_en,
   input  logic        src0_er,
   input  logic [7:0]  src0_data,
   input  logic        src1_en,
   input  logic        src1_er,
   input  logic [7:0]  src1_data,
   output logic        tx_en,
   output logic        tx_er,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [7:0]  abort_cnt
);

   typedef enum logic [2:0] {IDLE, START, WAIT_EN, XMIT, ABORT, GAP} state_t;

   typedef struct packed {
      logic       en;
      logic       er;
      logic [7:0] data;
   } gmii_t;

   // Terminal values for the shared cycle/byte counter in each state.
   localparam logic [15:0] TO_LAST  = 16'(START_TIMEOUT - 1);
   localparam logic [15:0] MAX_LAST = 16'(MAX_FRAME);
   localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

   state_t      state, state_n;
   logic        sel, sel_n;     // granted source index
   logic        last, last_n;   // last-granted source, drives the tie-break
   logic [15:0] cnt, cnt_n;     // timeout / byte / gap counter, reused per state
   gmii_t       src;            // granted source, unregistered
   gmii_t       tx_q, tx_n;     // registered TX pins
   logic        frame_inc, abort_inc;
   logic        active;
   logic [1:0]  sel_oh;

   // Only the granted source is ever looked at.
   always_comb begin
      src = sel ? {src1_en, src1_er, src1_data} : {src0_en, src0_er, src0_data};
   end

   // Next-state, arbitration and next TX byte.
   always_comb begin
      state_n   = state;
      sel_n     = sel;
      last_n    = last;
      cnt_n     = cnt;
      tx_n      = '0;
      frame_inc = 1'b0;
      abort_inc = 1'b0;
      case (state)
         IDLE: begin
            if (enable && (req != 2'b00)) begin
               // Single requester wins outright; on a tie the other-than-last source wins.
               sel_n   = (req == 2'b11) ? ~last : req[1];
               state_n = START;
            end
         end
         START: begin
            last_n  = sel;
            cnt_n   = '0;
            state_n = WAIT_EN;
         end
         WAIT_EN: begin
            if (src.en) begin
               // First byte is captured on the same edge that enters XMIT.
               tx_n    = src;
               cnt_n   = 16'd1;
               state_n = XMIT;
            end else if (cnt == TO_LAST) begin
               abort_inc = 1'b1;
               cnt_n     = '0;
               state_n   = GAP;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         XMIT: begin
            if (!src.en) begin
               frame_inc = 1'b1;
               cnt_n     = '0;
               state_n   = GAP;
            end else if (cnt >= MAX_LAST) begin
               // Runaway frame: the ABORT cycle shows an error byte on the pins.
               tx_n    = '{en: 1'b1, er: 1'b1, data: 8'h00};
               state_n = ABORT;
            end else begin
               tx_n  = src;
               cnt_n = cnt + 16'd1;
            end
         end
         ABORT: begin
            abort_inc = 1'b1;
            cnt_n     = '0;
            state_n   = GAP;
         end
         GAP: begin
            if (cnt == IFG_LAST) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, TX register and saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= 1'b0;
         last      <= 1'b1;
         cnt       <= '0;
         tx_q      <= '0;
         frame_cnt <= '0;
         abort_cnt <= '0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         last  <= last_n;
         cnt   <= cnt_n;
         tx_q  <= tx_n;
         if (frame_inc && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (abort_inc && (abort_cnt != 8'hFF)) begin
            abort_cnt <= abort_cnt + 8'd1;
         end
      end
   end

   // Grant and start decode straight from registered state, so they are glitch-free.
   always_comb begin
      active = (state == START) || (state == WAIT_EN) || (state == XMIT) || (state == ABORT);
      sel_oh = sel ? 2'b10 : 2'b01;
      gnt    = active ? sel_oh : 2'b00;
      start  = (state == START) ? sel_oh : 2'b00;
      busy   = (state != IDLE);
   end

   assign tx_en   = tx_q.en;
   assign tx_er   = tx_q.er;
   assign tx_data = tx_q.data;

endmodule

// File: tb/tb_ether_tx_scheduler.sv
// Bench for ether_tx_scheduler: table of frame scenarios plus hand-written enable and reset sequences.
// Source bytes are pushed to a scoreboard as driven and popped whenever tx_en is seen on the pins.
// Sources never stall; each scenario waits (bounded) for its start pulse and for the return to IDLE.
module tb_ether_tx_scheduler;

   localparam int IFG  = 12;
   localparam int TOUT = 16;
   localparam int MAXF = 1530;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [1:0]  req;
   logic [1:0]  start;
   logic [1:0]  gnt;
   logic        src0_en, src0_er, src1_en, src1_er;
   logic [7:0]  src0_data, src1_data;
   logic        tx_en, tx_er;
   logic [7:0]  tx_data;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [7:0]  abort_cnt;

   ether_tx_scheduler #(.IFG_CYCLES(IFG), .START_TIMEOUT(TOUT), .MAX_FRAME(MAXF)) dut (
      .clk(clk), .rst(rst), .enable(enable), .req(req), .start(start), .gnt(gnt),
      .src0_en(src0_en), .src0_er(src0_er), .src0_data(src0_data),
      .src1_en(src1_en), .src1_er(src1_er), .src1_data(src1_data),
      .tx_en(tx_en), .tx_er(tx_er), .tx_data(tx_data),
      .busy(busy), .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [1:0] req_after;
      int         k;       // expected winner
      int         dly;     // cycles in WAIT_EN before en; >= TOUT means never
      int         len;     // bytes driven by the source
      int         en_off;  // byte index at which enable drops, -1 for never
      int         frm;     // expected frame_cnt afterwards
      int         abt;     // expected abort_cnt afterwards
   } vec_t;

   vec_t       vt[11];
   logic [8:0] sb[$];      // {er, data} expected on the pins
   int         n_chk = 0;
   int         n_fail = 0;
   int         runs = 0;
   int         last_run = 0;
   int         run_len = 0;
   int         idle_len = 0;
   bit         prev_ok = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] fb(input int i, input int k);
      if (i < 7) return 8'h55;
      if (i == 7) return 8'hD5;
      return 8'((i * 13 + k * 128) & 255);
   endfunction

   function automatic int expb(input vec_t v);
      if (v.dly >= TOUT) return 13 + TOUT;
      if (v.len > MAXF) return 15 + v.dly + MAXF;
      return 14 + v.dly + v.len;
   endfunction

   task automatic drive(input int k, input logic en, input logic er, input logic [7:0] d);
      if (k == 0) begin
         src0_en = en; src0_er = er; src0_data = d;
      end else begin
         src1_en = en; src1_er = er; src1_data = d;
      end
   endtask

   // Pin monitor: scoreboard pops, one-hot grant, inter-frame gap, run lengths.
   always @(negedge clk) begin
      logic [8:0] e;
      n_chk++;
      if (gnt == 2'b11) begin
         n_fail++;
         $display("FAIL gnt_onehot: got %b required one-hot or zero", gnt);
      end
      if (tx_en === 1'b1) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: got er=%b data=%h with nothing expected", tx_er, tx_data);
         end else begin
            e = sb.pop_front();
            if ({tx_er, tx_data} !== e) begin
               n_fail++;
               $display("FAIL tx_byte: got er=%b data=%h expected er=%b data=%h", tx_er, tx_data, e[8], e[7:0]);
            end
         end
         if (run_len == 0) begin
            if (prev_ok) begin
               n_chk++;
               if (idle_len < IFG) begin
                  n_fail++;
                  $display("FAIL ifg_gap: got %0d idle cycles, need at least %0d", idle_len, IFG);
               end
            end
            runs++;
         end
         run_len++;
         idle_len = 0;
      end else begin
         if (run_len != 0) begin
            last_run = run_len;
            prev_ok  = 1'b1;
         end
         run_len = 0;
         idle_len++;
      end
      if (rst) begin
         prev_ok = 1'b0;
         run_len = 0;
         idle_len = 0;
      end
   end

   task automatic run_vec(input vec_t v);
      logic [1:0] oh;
      int nb;
      int runs0;
      oh = (v.k == 1) ? 2'b10 : 2'b01;
      req = v.req;
      runs0 = runs;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (start != 2'b00) break;
      end
      chk("start_winner", start, oh);
      if (start == 2'b00) return;
      req = v.req_after;
      nb = 0;
      fork
         begin : drv
            if (v.dly < TOUT) begin
               repeat (v.dly + 1) @(negedge clk);
               for (int i = 0; i < v.len; i++) begin
                  drive(v.k, 1'b1, (i == 20), fb(i, v.k));
                  drive(1 - v.k, 1'b1, 1'b0, 8'hEE);
                  if (i < MAXF) sb.push_back({(i == 20), fb(i, v.k)});
                  else if (i == MAXF) sb.push_back(9'h100);
                  if (i == v.en_off) enable = 1'b0;
                  @(negedge clk);
               end
               drive(0, 1'b0, 1'b0, 8'h00);
               drive(1, 1'b0, 1'b0, 8'h00);
            end
         end
         begin : bsy
            for (int c = 0; c < 2200; c++) begin
               @(negedge clk);
               nb++;
               if (nb == 1) begin
                  chk("start_one_cycle", start, 2'b00);
                  chk("gnt_hold", gnt, oh);
               end
               if (!busy) break;
            end
         end
      join
      chk("busy_cycles", nb, expb(v));
      chk("frame_cnt", frame_cnt, v.frm);
      chk("abort_cnt", abort_cnt, v.abt);
      chk("sb_drained", sb.size(), 0);
      chk("tx_runs", runs - runs0, (v.len > 0 && v.dly < TOUT) ? 1 : 0);
      if (v.len > 0 && v.dly < TOUT)
         chk("tx_run_len", last_run, (v.len > MAXF) ? MAXF + 1 : v.len);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      //          req    after  k dly  len  off frm abt
      vt[0]  = '{2'b01, 2'b00, 0, 2,   73,  -1, 1, 0};
      vt[1]  = '{2'b10, 2'b00, 1, 0,   60,  -1, 2, 0};
      vt[2]  = '{2'b11, 2'b11, 0, 1,   64,  -1, 3, 0};
      vt[3]  = '{2'b11, 2'b11, 1, 5,   70,  -1, 4, 0};
      vt[4]  = '{2'b11, 2'b11, 0, 15,  64,  -1, 5, 0};
      vt[5]  = '{2'b11, 2'b00, 1, 0,   80,  -1, 6, 0};
      vt[6]  = '{2'b01, 2'b00, 0, TOUT, 0,  -1, 6, 1};
      vt[7]  = '{2'b10, 2'b00, 1, 0,   2000, -1, 6, 2};
      vt[8]  = '{2'b11, 2'b00, 0, 0,   1,   -1, 7, 2};
      vt[9]  = '{2'b11, 2'b11, 1, 2,   40,  10, 8, 2};
      vt[10] = '{2'b11, 2'b00, 0, 3,   10,  -1, 9, 2};

      rst = 1'b1; enable = 1'b0; req = 2'b00;
      drive(0, 1'b0, 1'b0, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_er", tx_er, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_abort_cnt", abort_cnt, 0);

      enable = 1'b1;
      for (int i = 0; i < 10; i++) run_vec(vt[i]);

      // enable dropped mid-frame in vt[9]: no grant while it stays low, even with req=11.
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (start != 2'b00 || busy) seen = 1'b1;
      end
      chk("no_grant_while_disabled", seen, 0);
      enable = 1'b1;
      run_vec(vt[10]);

      // Reset at byte 0x20 of a source-0 frame.
      req = 2'b01;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (start != 2'b00) break;
      end
      chk("rst_test_start", start, 2'b01);
      req = 2'b00;
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         drive(0, 1'b1, 1'b0, fb(i, 0));
         drive(1, 1'b1, 1'b0, 8'hEE);
         sb.push_back({1'b0, fb(i, 0)});
         @(negedge clk);
      end
      drive(0, 1'b1, 1'b0, fb(32, 0));
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx_en", tx_en, 0);
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_gnt", gnt, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      chk("midrst_abort_cnt", abort_cnt, 0);
      drive(0, 1'b0, 1'b0, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_sb_drained", sb.size(), 0);
      run_vec('{2'b11, 2'b00, 0, 1, 30, -1, 1, 0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
